// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access codes, FSM states, and helpers
// for sizing the timeout counter and classifying accesses.
package lsu_pkg;

    typedef enum logic [2:0] {
        FC_LB  = 3'b000,
        FC_LBU = 3'b001,
        FC_LH  = 3'b010,
        FC_LHU = 3'b011,
        FC_LW  = 3'b100,
        FC_SB  = 3'b101,
        FC_SH  = 3'b110,
        FC_SW  = 3'b111
    } lsuFc_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsuState_t;

    // Wide enough to hold counts 0..maxCount.
    function automatic int cntWidth(input int maxCount);
        return $clog2(maxCount + 1);
    endfunction

    function automatic logic isStore(input lsuFc_t fc);
        return (fc == FC_SB) || (fc == FC_SH) || (fc == FC_SW);
    endfunction

    function automatic logic isMisaligned(input lsuFc_t fc, input logic [1:0] addrLo);
        case (fc)
            FC_LH, FC_LHU, FC_SH: return addrLo[0];
            FC_LW, FC_SW:         return addrLo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational data formatting: store byte enables and lane replication,
// plus load lane selection with sign/zero extension.
module lsu_fmt
    import lsu_pkg::*;
(
    input  lsuFc_t      stFc,
    input  logic [1:0]  stAddrLo,
    input  logic [31:0] stData,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    input  lsuFc_t      ldFc,
    input  logic [1:0]  ldAddrLo,
    input  logic [31:0] ldData,
    output logic [31:0] loadData
);

    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    always_comb begin
        memBe    = 4'b1111;
        memWdata = '0;
        case (stFc)
            FC_SB: begin
                memBe    = 4'b0001 << stAddrLo;
                memWdata = {4{stData[7:0]}};
            end
            FC_SH: begin
                memBe    = stAddrLo[1] ? 4'b1100 : 4'b0011;
                memWdata = {2{stData[15:0]}};
            end
            FC_SW:   memWdata = stData;
            default: ;
        endcase
    end

    // Halfword lane only looks at addr[1]; a stray addr[0] is ignored.
    always_comb begin
        ldByte = ldData[7:0];
        case (ldAddrLo)
            2'd1:    ldByte = ldData[15:8];
            2'd2:    ldByte = ldData[23:16];
            2'd3:    ldByte = ldData[31:24];
            default: ldByte = ldData[7:0];
        endcase
        ldHalf = ldAddrLo[1] ? ldData[31:16] : ldData[15:0];

        loadData = '0;
        case (ldFc)
            FC_LB:   loadData = {{24{ldByte[7]}}, ldByte};
            FC_LBU:  loadData = {24'd0, ldByte};
            FC_LH:   loadData = {{16{ldHalf[15]}}, ldHalf};
            FC_LHU:  loadData = {16'd0, ldHalf};
            FC_LW:   loadData = ldData;
            default: loadData = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with bus timeout and flush handling.
// Optional LSU_MISALIGN_EXC_EN: misaligned LH/LHU/SH/LW/SW respond with an exception, no bus access.
//   state   | meaning
//   IDLE    | ready for a new request
//   REQ     | mem_req asserted, waiting for mem_gnt
//   WAIT    | granted, waiting for mem_rvalid or timeout
//   RESP    | one-cycle response (suppressed if dropped or flushed)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fc,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_exc,
    output logic              busy
);

    localparam int              CNT_W    = cntWidth(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsuState_t        state;
    logic [CNT_W-1:0] waitCnt;
    logic             dropResp;
    lsuFc_t           fcQ;
    logic [1:0]       addrLoQ;
    lsuFc_t           reqFc;
    logic             accept;
    logic             reqMisaligned;
    logic [3:0]       beNext;
    logic [31:0]      wdataNext;
    logic [31:0]      loadData;

    assign reqFc  = lsuFc_t'(req_fc);
    assign accept = req_valid && (state == ST_IDLE);

`ifdef LSU_MISALIGN_EXC_EN
    assign reqMisaligned = isMisaligned(reqFc, req_addr[1:0]);
`else
    assign reqMisaligned = 1'b0;
`endif

    lsu_fmt uFmt (
        .stFc     (reqFc),
        .stAddrLo (req_addr[1:0]),
        .stData   (req_wdata),
        .memBe    (beNext),
        .memWdata (wdataNext),
        .ldFc     (fcQ),
        .ldAddrLo (addrLoQ),
        .ldData   (mem_rdata),
        .loadData (loadData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            waitCnt    <= '0;
            dropResp   <= 1'b0;
            fcQ        <= FC_LB;
            addrLoQ    <= 2'b00;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_exc   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        fcQ      <= reqFc;
                        addrLoQ  <= req_addr[1:0];
                        resp_rd  <= req_rd;
                        dropResp <= 1'b0;
                        if (reqMisaligned) begin
                            state      <= ST_RESP;
                            resp_exc   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state     <= ST_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= isStore(reqFc);
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= beNext;
                            mem_wdata <= wdataNext;
                        end
                    end
                end
                ST_REQ: begin
                    // A flush coinciding with the grant still aborts.
                    if (flush) begin
                        state   <= ST_IDLE;
                        mem_req <= 1'b0;
                    end else if (mem_gnt) begin
                        state   <= ST_WAIT;
                        mem_req <= 1'b0;
                        waitCnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (flush) dropResp <= 1'b1;
                    if (mem_rvalid) begin
                        state      <= ST_RESP;
                        resp_exc   <= 1'b0;
                        resp_rdata <= loadData;
                    end else if (waitCnt == CNT_LAST) begin
                        state      <= ST_RESP;
                        resp_exc   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_exc   <= 1'b0;
                    resp_rdata <= '0;
                    dropResp   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Flush must be able to kill the response in the RESP cycle itself.
    assign resp_valid = (state == ST_RESP) && !dropResp && !flush;
    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, corner-case
// sequences and randomized transactions against a transaction-level model.
module tb_load_store_unit;

    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        rst, flush, req_valid, req_ready;
    logic [2:0]  req_fc;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_exc, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_fc(req_fc),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_exc(resp_exc), .busy(busy)
    );

    // g: mem_req cycles before gnt; r: WAIT cycle index of rvalid (-1 never);
    // f: relative cycle of a one-cycle flush (-1 none); cycle 0 is the accept.
    typedef struct {
        logic [2:0]  fc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          g;
        int          r;
        int          f;
        bit          noise;
        bit          hold;
    } txn_t;

    typedef struct {
        int          reqCycles;
        int          firstReq;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          respCycle;
        logic        exc;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          readyCycle;
        bit          busyOk;
        bit          stableOk;
    } obs_t;

    typedef struct {
        txn_t        t;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic        expWe;
        logic [31:0] expRdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
        end
    endtask

    function automatic txn_t mkTxn(input logic [2:0] fc, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input logic [4:0] rd);
        txn_t t;
        t.fc = fc; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.rd = rd;
        t.g = 0; t.r = 0; t.f = -1; t.noise = 1'b0; t.hold = 1'b0;
        return t;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit misRef(input logic [2:0] fc, input logic [31:0] addr);
`ifdef LSU_MISALIGN_EXC_EN
        if ((fc == 3'd2 || fc == 3'd3 || fc == 3'd6) && (addr % 2 != 0)) return 1'b1;
        if ((fc == 3'd4 || fc == 3'd7) && (addr % 4 != 0)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] loadRef(input logic [2:0] fc, input logic [31:0] addr,
                                            input logic [31:0] rdata);
        int v;
        case (fc)
            3'd0, 3'd1: begin
                v = int'((rdata >> (8 * (addr % 4))) & 32'hFF);
                if (fc == 3'd0 && v > 127) v = v - 256;
                return v;
            end
            3'd2, 3'd3: begin
                v = int'((rdata >> (8 * (addr & 2))) & 32'hFFFF);
                if (fc == 3'd2 && v > 32767) v = v - 65536;
                return v;
            end
            3'd4:    return rdata;
            default: return 32'd0;
        endcase
    endfunction

    function automatic obs_t expectTxn(input txn_t t);
        obs_t e;
        int   gc, done, resp;
        e.reqCycles = 0; e.firstReq = -1; e.we = 1'b0; e.addr = 0; e.be = 0; e.wdata = 0;
        e.respCycle = -1; e.exc = 1'b0; e.rdata = 0; e.rd = t.rd; e.readyCycle = -1;
        e.busyOk = 1'b1; e.stableOk = 1'b1;
        if (misRef(t.fc, t.addr)) begin
            e.exc = 1'b1;
            e.respCycle = (t.f == 1) ? -1 : 1;
            e.readyCycle = 2;
            return e;
        end
        e.firstReq = 1;
        e.we    = (t.fc >= 3'd5);
        e.addr  = t.addr & ~32'd3;
        e.be    = (t.fc == 3'd5) ? 4'(1 << (t.addr % 4)) :
                  (t.fc == 3'd6) ? 4'(3 << (t.addr & 2)) : 4'hF;
        e.wdata = (t.fc == 3'd5) ? (t.wdata & 32'hFF) * 32'h01010101 :
                  (t.fc == 3'd6) ? (t.wdata & 32'hFFFF) * 32'h00010001 : t.wdata;
        gc = 1 + t.g;
        if (t.f >= 1 && t.f <= gc) begin
            e.reqCycles  = t.f;
            e.readyCycle = t.f + 1;
            return e;
        end
        e.reqCycles = t.g + 1;
        if (t.r >= 0 && t.r < TO) begin
            done    = gc + 1 + t.r;
            e.rdata = loadRef(t.fc, t.addr, t.rdata);
        end else begin
            done  = gc + TO;
            e.exc = 1'b1;
        end
        resp = done + 1;
        e.readyCycle = resp + 1;
        e.respCycle  = (t.f > gc && t.f <= resp) ? -1 : resp;
        return e;
    endfunction

    // ---------------- transaction driver / monitor ----------------
    task automatic runTxn(input txn_t t, output obs_t o);
        int gntCycle = -1;
        int reqSeen  = 0;
        o.reqCycles = 0; o.firstReq = -1; o.we = 1'b0; o.addr = 0; o.be = 0; o.wdata = 0;
        o.respCycle = -1; o.exc = 1'b0; o.rdata = 0; o.rd = 0; o.readyCycle = -1;
        o.busyOk = 1'b1; o.stableOk = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            req_valid  = (c == 0) || (t.hold && !req_ready);
            req_fc     = t.fc;
            req_addr   = t.addr;
            req_wdata  = t.wdata;
            req_rd     = t.rd;
            mem_rdata  = t.rdata;
            mem_gnt    = mem_req && (reqSeen >= t.g);
            mem_rvalid = (t.noise && gntCycle < 0) ||
                         (t.r >= 0 && gntCycle >= 0 && c == gntCycle + 1 + t.r);
            flush      = (c == t.f);
            #1;
            if (mem_req) begin
                if (o.reqCycles == 0) begin
                    o.firstReq = c; o.we = mem_we; o.addr = mem_addr;
                    o.be = mem_be; o.wdata = mem_wdata;
                end else if (mem_we !== o.we || mem_addr !== o.addr ||
                             mem_be !== o.be || mem_wdata !== o.wdata) begin
                    o.stableOk = 1'b0;
                end
                o.reqCycles++;
                reqSeen++;
                if (mem_gnt) gntCycle = c;
            end
            if (resp_valid && o.respCycle < 0) begin
                o.respCycle = c; o.exc = resp_exc; o.rdata = resp_rdata; o.rd = resp_rd;
            end
            if (c > 0 && req_ready) begin
                o.readyCycle = c;
                if (busy) o.busyOk = 1'b0;
                break;
            end
            if (c > 0 && !busy) o.busyOk = 1'b0;
        end
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; flush = 1'b0;
    endtask

    task automatic checkTxn(input string tag, input obs_t got, input obs_t exp);
        chk({tag, ".reqCycles"},  got.reqCycles,  exp.reqCycles);
        chk({tag, ".readyCycle"}, got.readyCycle, exp.readyCycle);
        chk({tag, ".respCycle"},  got.respCycle,  exp.respCycle);
        chk({tag, ".busy"},       got.busyOk,     exp.busyOk);
        if (exp.reqCycles > 0) begin
            chk({tag, ".firstReq"}, got.firstReq, exp.firstReq);
            chk({tag, ".stable"},   got.stableOk, exp.stableOk);
            chk({tag, ".memWe"},    got.we,       exp.we);
            chk({tag, ".memAddr"},  got.addr,     exp.addr);
            chk({tag, ".memBe"},    got.be,       exp.be);
            if (exp.we) chk({tag, ".memWdata"}, got.wdata, exp.wdata);
        end
        if (exp.respCycle >= 0) begin
            chk({tag, ".respExc"},   got.exc,   exp.exc);
            chk({tag, ".respRdata"}, got.rdata, exp.rdata);
            chk({tag, ".respRd"},    got.rd,    exp.rd);
        end
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[10];

    initial begin
        txn_t t;
        obs_t o, e;
        bit   sawResp;

        vecs[0] = '{mkTxn(3'd0, 32'h1003, 32'h0, 32'h80FFFFFF, 5'd1), 32'h1000, 4'hF, 32'h0, 1'b0, 32'hFFFFFF80};
        vecs[1] = '{mkTxn(3'd2, 32'h2002, 32'h0, 32'h80011234, 5'd2), 32'h2000, 4'hF, 32'h0, 1'b0, 32'hFFFF8001};
        vecs[2] = '{mkTxn(3'd3, 32'h2002, 32'h0, 32'h80011234, 5'd3), 32'h2000, 4'hF, 32'h0, 1'b0, 32'h00008001};
        vecs[3] = '{mkTxn(3'd5, 32'h3001, 32'h000000AB, 32'h0, 5'd4), 32'h3000, 4'b0010, 32'hABABABAB, 1'b1, 32'h0};
        vecs[4] = '{mkTxn(3'd1, 32'h1001, 32'h0, 32'h12345678, 5'd5), 32'h1000, 4'hF, 32'h0, 1'b0, 32'h00000056};
        vecs[5] = '{mkTxn(3'd6, 32'h3002, 32'h0000BEEF, 32'h0, 5'd6), 32'h3000, 4'b1100, 32'hBEEFBEEF, 1'b1, 32'h0};
        vecs[6] = '{mkTxn(3'd7, 32'h3000, 32'hDEADBEEF, 32'h0, 5'd7), 32'h3000, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0};
        vecs[7] = '{mkTxn(3'd4, 32'h3004, 32'h0, 32'hCAFEF00D, 5'd8), 32'h3004, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D};
        vecs[8] = '{mkTxn(3'd0, 32'h1000, 32'h0, 32'h0000007F, 5'd9), 32'h1000, 4'hF, 32'h0, 1'b0, 32'h0000007F};
        vecs[9] = '{mkTxn(3'd2, 32'h2000, 32'h0, 32'h0000F00F, 5'd10), 32'h2000, 4'hF, 32'h0, 1'b0, 32'hFFFFF00F};

        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_fc = 3'd0; req_addr = 0;
        req_wdata = 0; req_rd = 0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.reqReady",  req_ready,  1'b1);
        chk("rst.busy",      busy,       1'b0);
        chk("rst.memReq",    mem_req,    1'b0);
        chk("rst.memWe",     mem_we,     1'b0);
        chk("rst.memAddr",   mem_addr,   32'h0);
        chk("rst.memBe",     mem_be,     4'h0);
        chk("rst.memWdata",  mem_wdata,  32'h0);
        chk("rst.respValid", resp_valid, 1'b0);
        chk("rst.respExc",   resp_exc,   1'b0);
        chk("rst.respRdata", resp_rdata, 32'h0);
        chk("rst.respRd",    resp_rd,    5'h0);
        rst = 1'b0;

        // Directed vectors: immediate gnt and rvalid, response at T+3.
        for (int i = 0; i < 10; i++) begin
            runTxn(vecs[i].t, o);
            e.reqCycles = 1; e.firstReq = 1; e.we = vecs[i].expWe; e.addr = vecs[i].expAddr;
            e.be = vecs[i].expBe; e.wdata = vecs[i].expWdata; e.respCycle = 3; e.exc = 1'b0;
            e.rdata = vecs[i].expRdata; e.rd = vecs[i].t.rd; e.readyCycle = 4;
            e.busyOk = 1'b1; e.stableOk = 1'b1;
            checkTxn($sformatf("vec%0d", i), o, e);
        end

        // LW, gnt withheld 3 cycles, rvalid never: timeout.
        t = mkTxn(3'd4, 32'h7000, 32'h0, 32'h55AA55AA, 5'd11);
        t.g = 3; t.r = -1;
        runTxn(t, o);
        checkTxn("timeout", o, expectTxn(t));
        chk("timeout.memReqCycles", o.reqCycles, 4);
        chk("timeout.respCycle",    o.respCycle, 5 + TO);
        chk("timeout.exc",          o.exc,       1'b1);

        // rvalid in the last WAIT cycle beats the timeout.
        t = mkTxn(3'd4, 32'h7004, 32'h0, 32'h13579BDF, 5'd12);
        t.r = TO - 1;
        runTxn(t, o);
        checkTxn("lastCycle", o, expectTxn(t));
        chk("lastCycle.exc", o.exc, 1'b0);

        // Flush in WAIT, rvalid two cycles later: no response.
        t = mkTxn(3'd4, 32'h6000, 32'h0, 32'h11112222, 5'd13);
        t.r = 2; t.f = 2;
        runTxn(t, o);
        checkTxn("flushWait", o, expectTxn(t));
        chk("flushWait.readyCycle", o.readyCycle, 6);

        // Flush together with gnt aborts.
        t = mkTxn(3'd7, 32'h6100, 32'h01020304, 32'h0, 5'd14);
        t.g = 1; t.f = 2; t.noise = 1'b1;
        runTxn(t, o);
        checkTxn("flushGnt", o, expectTxn(t));

        // Flush in RESP suppresses the response.
        t = mkTxn(3'd0, 32'h6200, 32'h0, 32'h000000FF, 5'd15);
        t.f = 3;
        runTxn(t, o);
        checkTxn("flushResp", o, expectTxn(t));

        // SW to a misaligned word address.
        t = mkTxn(3'd7, 32'h4002, 32'h11223344, 32'h0, 5'd16);
        runTxn(t, o);
        checkTxn("sw4002", o, expectTxn(t));
`ifdef LSU_MISALIGN_EXC_EN
        chk("sw4002.memReqCycles", o.reqCycles, 0);
        chk("sw4002.respCycle",    o.respCycle, 1);
        chk("sw4002.exc",          o.exc,       1'b1);
`else
        chk("sw4002.memAddr", o.addr, 32'h4000);
        chk("sw4002.memBe",   o.be,   4'hF);
`endif

        // Reset in WAIT abandons the transaction; a late rvalid is ignored.
        sawResp = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_fc = 3'd4; req_addr = 32'h5000; req_rd = 5'd9;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            req_valid  = 1'b0;
            mem_gnt    = (c == 1);
            rst        = (c == 3);
            mem_rvalid = (c == 5);
            #1;
            if (resp_valid) sawResp = 1'b1;
            if (c == 4) begin
                chk("rstMid.reqReady", req_ready, 1'b1);
                chk("rstMid.memReq",   mem_req,   1'b0);
                chk("rstMid.memAddr",  mem_addr,  32'h0);
            end
        end
        chk("rstMid.noResp", sawResp, 1'b0);
        rst = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;

        // Randomized transactions against the model.
        for (int i = 0; i < 150; i++) begin
            t = mkTxn(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 5'($urandom));
            t.g     = $urandom_range(0, 3);
            t.r     = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO + 1));
            t.f     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TO + 6)) : -1;
            t.noise = 1'($urandom_range(0, 1));
            t.hold  = 1'($urandom_range(0, 1));
            runTxn(t, o);
            checkTxn($sformatf("rnd%0d", i), o, expectTxn(t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
